// File: rtl/oled_text_terminal.sv
`timescale 1ns/1ps
// ASCII byte stream to OLED controller command handshakes.
// Tracks a 4x16 cursor and issues display-on, write and update commands.
module oled_text_terminal #(
    parameter bit AUTO_UPDATE       = 1'b1,
    parameter bit POWER_ON_AT_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       char_valid,
    input  logic [7:0] char_data,
    output logic       char_ready,
    input  logic       flush,
    input  logic       power_on,
    output logic       busy,
    output logic [1:0] cursor_row,
    output logic [3:0] cursor_col,
    output logic       disp_on_start,
    input  logic       disp_on_ready,
    output logic       write_start,
    output logic [7:0] write_ascii_data,
    output logic [8:0] write_base_addr,
    input  logic       write_ready,
    output logic       update_start,
    output logic       update_clear,
    input  logic       update_ready
);

    typedef enum logic [2:0] {
        RST_WAIT, IDLE_OFF, ISSUE, HOLD, WAIT_RDY, IDLE, CLR_NEXT
    } state_t;

    typedef enum logic [1:0] {CMD_ON, CMD_WRITE, CMD_UPD} cmd_t;

    state_t     state, state_n, ret, ret_n;
    cmd_t       cmd, cmd_n;
    logic [1:0] row_n;
    logic [3:0] col_n;
    logic [7:0] data_n;
    logic [8:0] addr_n;
    logic [6:0] cnt, cnt_n;
    logic       flush_pend, pwr_pend;
    logic       flush_clr, pwr_clr;
    logic       rdy;
    logic       printable;

    assign disp_on_start = (state == ISSUE) && (cmd == CMD_ON);
    assign write_start   = (state == ISSUE) && (cmd == CMD_WRITE);
    assign update_start  = (state == ISSUE) && (cmd == CMD_UPD);
    assign update_clear  = 1'b0;
    assign busy          = (state != IDLE);
    assign char_ready    = (state == IDLE) && !flush_pend;
    assign printable     = (char_data >= 8'h20) && (char_data <= 8'h7E);
    // Display-on completion shows up as the controller becoming update-ready.
    assign rdy = (cmd == CMD_WRITE) ? write_ready : update_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RST_WAIT;
            ret              <= IDLE;
            cmd              <= CMD_ON;
            cursor_row       <= '0;
            cursor_col       <= '0;
            write_ascii_data <= '0;
            write_base_addr  <= '0;
            cnt              <= '0;
            flush_pend       <= 1'b0;
            pwr_pend         <= 1'b0;
        end else begin
            state            <= state_n;
            ret              <= ret_n;
            cmd              <= cmd_n;
            cursor_row       <= row_n;
            cursor_col       <= col_n;
            write_ascii_data <= data_n;
            write_base_addr  <= addr_n;
            cnt              <= cnt_n;
            flush_pend       <= flush | (flush_pend & ~flush_clr);
            pwr_pend         <= power_on | (pwr_pend & ~pwr_clr);
        end
    end

    always_comb begin
        state_n   = state;
        ret_n     = ret;
        cmd_n     = cmd;
        row_n     = cursor_row;
        col_n     = cursor_col;
        data_n    = write_ascii_data;
        addr_n    = write_base_addr;
        cnt_n     = cnt;
        flush_clr = 1'b0;
        pwr_clr   = 1'b0;
        unique case (state)
            RST_WAIT: begin
                if (update_ready) begin
                    state_n = IDLE;
                end else if (disp_on_ready) begin
                    if (POWER_ON_AT_RESET) begin
                        cmd_n   = CMD_ON;
                        ret_n   = IDLE;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE_OFF;
                    end
                end
            end
            IDLE_OFF: begin
                if (pwr_pend) begin
                    pwr_clr = 1'b1;
                    cmd_n   = CMD_ON;
                    ret_n   = IDLE;
                    state_n = ISSUE;
                end
            end
            ISSUE: state_n = HOLD;
            HOLD:  state_n = WAIT_RDY;
            WAIT_RDY: begin
                if (rdy) state_n = ret;
            end
            IDLE: begin
                if (flush_pend) begin
                    flush_clr = 1'b1;
                    cmd_n     = CMD_UPD;
                    ret_n     = IDLE;
                    state_n   = ISSUE;
                end else if (char_valid) begin
                    unique case (1'b1)
                        printable: begin
                            data_n         = char_data;
                            addr_n         = {cursor_row, cursor_col, 3'b000};
                            {row_n, col_n} = {cursor_row, cursor_col} + 6'd1;
                            cmd_n          = CMD_WRITE;
                            ret_n          = IDLE;
                            state_n        = ISSUE;
                        end
                        (char_data == 8'h0D): col_n = '0;
                        (char_data == 8'h0A): begin
                            col_n = '0;
                            row_n = cursor_row + 2'd1;
                            if (AUTO_UPDATE) begin
                                cmd_n   = CMD_UPD;
                                ret_n   = IDLE;
                                state_n = ISSUE;
                            end
                        end
                        (char_data == 8'h0C): begin
                            row_n   = '0;
                            col_n   = '0;
                            cnt_n   = '0;
                            state_n = CLR_NEXT;
                        end
                        default: ;
                    endcase
                end
            end
            CLR_NEXT: begin
                // cnt[6] set means all 64 cells have been blanked.
                if (cnt[6]) begin
                    if (AUTO_UPDATE) begin
                        cmd_n   = CMD_UPD;
                        ret_n   = IDLE;
                        state_n = ISSUE;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    data_n  = 8'h20;
                    addr_n  = {cnt[5:0], 3'b000};
                    cnt_n   = cnt + 7'd1;
                    cmd_n   = CMD_WRITE;
                    ret_n   = CLR_NEXT;
                    state_n = ISSUE;
                end
            end
            default: state_n = RST_WAIT;
        endcase
    end

endmodule
